// File: rtl/vol_sci_sched_if.sv
// Signal bundle between the volume/SCI scheduler and its surroundings.
// Grouped here so the button, arbiter and decoder pins travel as one port.
interface vol_sci_sched_if;
  // Bus handshake: BUS_REQ rises when a frame is pending and stays high for the
  // whole frame. A cycle with BUS_REQ & BUS_GNT is the transfer point. After
  // that point the grant must stay asserted until BUS_REQ falls.
  logic        UP;
  logic        DOWN;
  logic        DREQ;
  logic        BUS_GNT;
  logic        BUS_REQ;
  logic        XCS;
  logic        SCLK;
  logic        SI;
  logic [15:0] VOL;
  logic        BUSY;
  logic [2:0]  STATE;

  modport slave (
    input  UP, DOWN, DREQ, BUS_GNT,
    output BUS_REQ, XCS, SCLK, SI, VOL, BUSY, STATE
  );

  modport master (
    output UP, DOWN, DREQ, BUS_GNT,
    input  BUS_REQ, XCS, SCLK, SI, VOL, BUSY, STATE
  );
endinterface

// File: rtl/vol_sci_sched.sv
// Button-driven stereo attenuation with a 32-bit SCI_VOL write frame.
// Frames are coalesced: any volume change while busy yields one more frame.
module vol_sci_sched #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [15:0] VOL_STEP = 16'h1010,
  parameter logic [15:0] VOL_MAX  = 16'hF0F0,
  parameter logic [15:0] VOL_INIT = 16'h0000
) (
  input logic            CLK,
  input logic            RST,
  vol_sci_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DREQ = 3'd2,
    S_SETUP     = 3'd3,
    S_SHIFT     = 3'd4,
    S_HOLD      = 3'd5
  } state_e;

  localparam int unsigned   CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  state_e        state_q, state_d;
  logic [15:0]   vol_q, vol_d;
  logic          pend_q, pend_d;
  logic [31:0]   shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic [4:0]    bit_q, bit_d;
  logic          frame_start;
  logic          vol_chg;
  logic          cnt_last;
  logic          in_frame;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      vol_q   <= VOL_INIT;
      pend_q  <= 1'b1;
      shift_q <= '0;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      vol_q   <= vol_d;
      pend_q  <= pend_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
    end
  end

  // Volume is independent of the frame FSM; presses land in every state.
  always_comb begin
    vol_d   = vol_q;
    vol_chg = 1'b0;
    if (bus.UP && !bus.DOWN && vol_q != 16'h0000) begin
      vol_d   = vol_q - VOL_STEP;
      vol_chg = 1'b1;
    end else if (bus.DOWN && !bus.UP && vol_q != VOL_MAX) begin
      vol_d   = vol_q + VOL_STEP;
      vol_chg = 1'b1;
    end
  end

  // A change in the latch cycle wins, so that value still gets its own frame.
  always_comb begin
    pend_d = pend_q;
    if (frame_start) pend_d = 1'b0;
    if (vol_chg)     pend_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    bit_d       = bit_q;
    frame_start = 1'b0;
    cnt_last    = (cnt_q == CNT_LAST);
    case (state_q)
      S_IDLE: begin
        if (pend_q) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.BUS_GNT) state_d = S_WAIT_DREQ;
      end
      S_WAIT_DREQ: begin
        if (bus.DREQ) begin
          state_d     = S_SETUP;
          shift_d     = {8'h02, 8'h0B, vol_q};
          cnt_d       = '0;
          frame_start = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_last) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (!cnt_last) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            // Falling SCLK edge: the only point where SI may move.
            half_d  = 1'b0;
            shift_d = {shift_q[30:0], 1'b0};
            if (bit_q == 5'd31) state_d = S_HOLD;
            else                bit_d   = bit_q + 5'd1;
          end
        end
      end
      S_HOLD: begin
        if (cnt_last) state_d = S_IDLE;
        else          cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_frame    = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
  assign bus.XCS     = !in_frame;
  assign bus.SCLK    = (state_q == S_SHIFT) && half_q;
  assign bus.SI      = in_frame && shift_q[31];
  assign bus.BUS_REQ = (state_q != S_IDLE);
  assign bus.BUSY    = (state_q != S_IDLE);
  assign bus.VOL     = vol_q;
  assign bus.STATE   = state_q;

endmodule

// File: tb/tb_vol_sci_sched.sv
// Directed bench for vol_sci_sched: a volume model plus an SCI frame decoder
// checked every cycle, and literal expectations for each scenario.
`timescale 1ns/1ps
module tb_vol_sci_sched;
  localparam int CLK_DIV   = 4;
  localparam int FRAME_LOW = 66 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vol_sci_sched_if bus();

  vol_sci_sched #(
    .CLK_DIV (CLK_DIV),
    .VOL_STEP(16'h1010),
    .VOL_MAX (16'hF0F0),
    .VOL_INIT(16'h0000)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] model_vol = 16'h0000;
  logic [15:0] prev_vol  = 16'h0000;
  logic        checking  = 1'b0;
  logic        rst_seen  = 1'b1;
  logic        prev_xcs  = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_si   = 1'b0;
  logic        prev_req  = 1'b0;
  logic        in_frame  = 1'b0;
  logic [31:0] word      = 32'h0;
  int          low_cnt   = 0;
  int          nbits     = 0;
  int          hi_run    = 0;
  int          frames    = 0;
  int          req_rises = 0;

  always @(negedge clk) begin
    if (checking) begin
      chk("vol_model", 32'(bus.VOL), 32'(model_vol));
      if (rst_seen) begin
        chk("reset_outputs", 32'({bus.XCS, bus.SCLK, bus.SI, bus.BUS_REQ, bus.BUSY}), 32'b10000);
        if (in_frame) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          in_frame = 1'b0;
        end
        hi_run = 0;
      end else begin
        if (!bus.XCS) chk("req_busy_in_frame", 32'({bus.BUS_REQ, bus.BUSY}), 32'b11);
        else          chk("sclk_idle_low", 32'(bus.SCLK), 32'd0);
        if (bus.BUS_REQ && !prev_req) req_rises++;
        if (prev_xcs && !bus.XCS) begin
          in_frame = 1'b1;
          low_cnt  = 0;
          nbits    = 0;
          word     = 32'h0;
          hi_run   = 0;
          exp_q.push_back({8'h02, 8'h0B, prev_vol});
        end
        if (!bus.XCS) begin
          low_cnt++;
          if (bus.SCLK && !prev_sclk) begin
            word = {word[30:0], bus.SI};
            nbits++;
          end
          if (bus.SCLK) hi_run++;
          if (!prev_xcs && prev_sclk && !bus.SCLK) begin
            chk("sclk_high_len", 32'(hi_run), 32'(CLK_DIV));
            hi_run = 0;
          end
          if (!prev_xcs && bus.SI !== prev_si)
            chk("si_moves_on_fall", 32'({prev_sclk, bus.SCLK}), 32'b10);
        end
        if (!prev_xcs && bus.XCS && in_frame) begin
          chk("frame_queued", 32'(exp_q.size() > 0), 32'd1);
          chk("frame_word", word, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
          chk("frame_bits", 32'(nbits), 32'd32);
          chk("xcs_low_len", 32'(low_cnt), 32'(FRAME_LOW));
          got_q.push_back(word);
          frames++;
          in_frame = 1'b0;
        end
      end
      prev_xcs  = bus.XCS;
      prev_sclk = bus.SCLK;
      prev_si   = bus.SI;
      prev_req  = bus.BUS_REQ;
      prev_vol  = model_vol;
      rst_seen  = rst;
      if (rst)
        model_vol = 16'h0000;
      else if (bus.UP && !bus.DOWN && model_vol != 16'h0000)
        model_vol = model_vol - 16'h1010;
      else if (bus.DOWN && !bus.UP && model_vol != 16'hF0F0)
        model_vol = model_vol + 16'h1010;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input logic up, input logic down);
    @(posedge clk); #1;
    bus.UP   = up;
    bus.DOWN = down;
    @(posedge clk); #1;
    bus.UP   = 1'b0;
    bus.DOWN = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int quiet = 0;
    int n     = 0;
    while (quiet < 8 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (bus.BUSY) quiet = 0;
      else          quiet++;
    end
    chk({name, "_quiet_timeout"}, 32'(quiet >= 8), 32'd1);
  endtask

  task automatic wait_xcs_low(input string name);
    int n = 0;
    while (bus.XCS && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_xcs_low_timeout"}, 32'(bus.XCS), 32'd0);
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] last_word(input int back);
    if (got_q.size() > back) return got_q[got_q.size() - 1 - back];
    return 32'hDEAD_BEEF;
  endfunction

  // ---------------- directed scenarios ----------------
  initial begin
    int f0;
    int r0;
    int bad;
    bus.UP      = 1'b0;
    bus.DOWN    = 1'b0;
    bus.DREQ    = 1'b1;
    bus.BUS_GNT = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    chk("reset_vol", 32'(bus.VOL), 32'h0000);
    chk("reset_xcs", 32'(bus.XCS), 32'd1);

    // Initial volume frame after reset release.
    wait_quiet("t1");
    chk("t1_frames", 32'(frames), 32'd1);
    chk("t1_word", last_word(0), 32'h020B_0000);
    chk("t1_low_len", 32'(low_cnt), 32'd264);

    // UP clamps at 0x0000 with no frame; then 16 DOWN presses saturate.
    f0 = frames;
    r0 = req_rises;
    press(1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("t2_up_clamp_vol", 32'(bus.VOL), 32'h0000);
    chk("t2_up_clamp_frames", 32'(frames - f0), 32'd0);
    chk("t2_up_clamp_req", 32'(req_rises - r0), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      press(1'b0, 1'b1);
      if (i == 15) chk("t2_vol_after_15", 32'(bus.VOL), 32'h0000_F0F0);
    end
    chk("t2_vol_after_16", 32'(bus.VOL), 32'h0000_F0F0);
    wait_quiet("t2");
    chk("t2_frames", 32'(frames - f0), 32'd2);
    chk("t2_first_word", last_word(1), 32'h020B_2020);
    chk("t2_last_word", last_word(0), 32'h020B_F0F0);

    // Simultaneous UP and DOWN at 0x3030 is ignored.
    for (int i = 0; i < 12; i++) press(1'b1, 1'b0);
    wait_quiet("t3a");
    chk("t3_vol_3030", 32'(bus.VOL), 32'h0000_3030);
    f0 = frames;
    r0 = req_rises;
    press(1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("t3_vol_same", 32'(bus.VOL), 32'h0000_3030);
    chk("t3_no_frame", 32'(frames - f0), 32'd0);
    chk("t3_no_req", 32'(req_rises - r0), 32'd0);

    // Presses during an active frame coalesce into one following frame.
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    wait_quiet("t4a");
    chk("t4_vol_zero", 32'(bus.VOL), 32'h0000);
    pulse_rst();
    f0 = frames;
    wait_xcs_low("t4");
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
    wait_quiet("t4b");
    chk("t4_frames", 32'(frames - f0), 32'd2);
    chk("t4_current_word", last_word(1), 32'h020B_0000);
    chk("t4_follow_word", last_word(0), 32'h020B_3030);

    // Slow grant, then slow DREQ.
    bus.BUS_GNT = 1'b0;
    bus.DREQ    = 1'b0;
    f0 = frames;
    press(1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!(bus.BUS_REQ && bus.XCS)) bad++;
    end
    chk("t5_req_no_gnt", 32'(bad), 32'd0);
    bus.BUS_GNT = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!(bus.BUS_REQ && bus.XCS)) bad++;
    end
    chk("t5_req_no_dreq", 32'(bad), 32'd0);
    bus.DREQ = 1'b1;
    chk("t5_xcs_at_dreq", 32'(bus.XCS), 32'd1);
    @(posedge clk); #1;
    chk("t5_xcs_after_dreq", 32'(bus.XCS), 32'd0);
    wait_quiet("t5");
    chk("t5_frames", 32'(frames - f0), 32'd1);
    chk("t5_word", last_word(0), 32'h020B_2020);

    // Reset in the middle of a 0x5050 frame.
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    wait_quiet("t6a");
    f0 = frames;
    press(1'b0, 1'b1);
    chk("t6_vol_5050", 32'(bus.VOL), 32'h0000_5050);
    wait_xcs_low("t6");
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t6_idle_pins", 32'({bus.XCS, bus.SCLK, bus.BUS_REQ}), 32'b100);
    chk("t6_vol_init", 32'(bus.VOL), 32'h0000);
    wait_quiet("t6b");
    chk("t6_frames", 32'(frames - f0), 32'd1);
    chk("t6_word", last_word(0), 32'h020B_0000);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "simulation time limit");
  end

endmodule
